// File: rtl/prt_scaler_lst.sv
// Scaler line store: ring of line slots behind a two-line, per-lane pop window.
// Latency: pop strobe to LST_DATx_OUT is exactly P_LAT cycles; writes land in one cycle.
// Backpressure: VID_RDY_OUT drops while the ring holds P_SLOTS-1 complete lines; pops are ignored while LST_RDY_OUT=0.
//
// Ports:
//   RST_IN / CLK_IN            async active-high reset, clock
//   CTL_RUN_IN / CTL_FS_IN     run enable (0 flushes), frame-start pulse
//   VID_VLD/EOL/DAT_IN, VID_RDY_OUT   4-pixel write words, EOL closes a line
//   LST_RD0/RD1_IN             per-lane pops for window lines 0/1 (bit3 = lane0)
//   LST_LRST_IN / LST_LNXT_IN  rewind window pointers / slide window one line
//   LST_DAT0/DAT1_OUT          last popped pixel per lane (lane i at [i*P_BPC+:P_BPC])
//   LST_RDY_OUT / LST_LVL_OUT  window valid / complete lines in ring
// Build option: PRT_SCALER_LST_CLAMP_EN -> pops past the end of a line replicate
//   the last pixel; otherwise they return 0.
module prt_scaler_lst #(
    parameter int P_BPC   = 8,
    parameter int P_SLOTS = 4,
    parameter int P_WRDS  = 1024,
    parameter int P_LAT   = 5
) (
    input  logic               RST_IN,
    input  logic               CLK_IN,
    input  logic               CTL_RUN_IN,
    input  logic               CTL_FS_IN,
    input  logic               VID_VLD_IN,
    input  logic               VID_EOL_IN,
    input  logic [4*P_BPC-1:0] VID_DAT_IN,
    output logic               VID_RDY_OUT,
    input  logic [3:0]         LST_RD0_IN,
    input  logic [3:0]         LST_RD1_IN,
    input  logic               LST_LRST_IN,
    input  logic               LST_LNXT_IN,
    output logic [4*P_BPC-1:0] LST_DAT0_OUT,
    output logic [4*P_BPC-1:0] LST_DAT1_OUT,
    output logic               LST_RDY_OUT,
    output logic [2:0]         LST_LVL_OUT
);
    localparam int SW  = $clog2(P_SLOTS);
    localparam int AW  = $clog2(P_WRDS);
    localparam int NST = P_LAT - 1;   // pipeline stages before the holding output register

    logic              r_act;         // set by FS, cleared by reset/idle
    logic              r_cmd_d;       // FS/LRST/LNXT seen last cycle
    logic [SW-1:0]     r_wslot;
    logic [AW-1:0]     r_waddr;
    logic [SW-1:0]     r_slot0;
    logic [P_SLOTS-1:0] r_cmp;
    logic [AW:0]       r_len [P_SLOTS];
    logic [2:0]        r_lvl;
    logic [AW-1:0]     r_rptr [2][4];
    logic [3:0]        r_end [2];     // lane has already returned its last word

    logic              w_clr;
    logic [SW-1:0]     w_slot1;
    logic [SW-1:0]     w_rslot [2];
    logic              w_vid_rdy;
    logic              w_wr;
    logic              w_eol;
    logic              w_dec;
    logic              w_lst_rdy;
    logic [3:0]        w_pop [2];
    logic [P_BPC-1:0]  w_lane [2][4];

    // Idle and frame start both wipe the ring state; FS additionally arms writing.
    assign w_clr      = ~CTL_RUN_IN | CTL_FS_IN;
    assign w_slot1    = r_slot0 + SW'(1);
    assign w_rslot[0] = r_slot0;
    assign w_rslot[1] = w_slot1;
    assign w_vid_rdy  = CTL_RUN_IN & r_act & (r_lvl != 3'(P_SLOTS - 1));
    assign w_wr       = VID_VLD_IN & w_vid_rdy & ~CTL_FS_IN;
    assign w_eol      = w_wr & VID_EOL_IN;
    assign w_dec      = LST_LNXT_IN & (r_lvl != 3'd0);
    assign w_lst_rdy  = CTL_RUN_IN & r_act & r_cmp[r_slot0] & r_cmp[w_slot1] & ~r_cmd_d;

    assign VID_RDY_OUT = w_vid_rdy;
    assign LST_RDY_OUT = w_lst_rdy;
    assign LST_LVL_OUT = r_lvl;

    always_comb begin
        w_pop[0] = '0;
        w_pop[1] = '0;
        for (int l = 0; l < 4; l++) begin
            w_pop[0][l] = w_lst_rdy & ~CTL_FS_IN & LST_RD0_IN[3-l];
            w_pop[1][l] = w_lst_rdy & ~CTL_FS_IN & LST_RD1_IN[3-l];
        end
    end

    // Write side, slot bookkeeping and window position.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            r_act   <= 1'b0;
            r_cmd_d <= 1'b0;
            r_wslot <= '0;
            r_waddr <= '0;
            r_slot0 <= '0;
            r_cmp   <= '0;
            r_lvl   <= '0;
            for (int s = 0; s < P_SLOTS; s++) r_len[s] <= '0;
        end else if (w_clr) begin
            r_act   <= CTL_RUN_IN;
            r_cmd_d <= CTL_RUN_IN;
            r_wslot <= '0;
            r_waddr <= '0;
            r_slot0 <= '0;
            r_cmp   <= '0;
            r_lvl   <= '0;
        end else begin
            r_cmd_d <= LST_LRST_IN | LST_LNXT_IN;
            if (w_wr) begin
                if (VID_EOL_IN) begin
                    r_len[r_wslot] <= {1'b0, r_waddr} + {{AW{1'b0}}, 1'b1};
                    r_wslot        <= r_wslot + SW'(1);
                    r_waddr        <= '0;
                end else if (r_waddr != AW'(P_WRDS - 1)) begin
                    r_waddr <= r_waddr + AW'(1);
                end
            end
            if (LST_LNXT_IN) begin
                r_slot0        <= w_slot1;
                r_cmp[r_slot0] <= 1'b0;
            end
            if (w_eol) r_cmp[r_wslot] <= 1'b1;
            if (w_eol && !w_dec)      r_lvl <= r_lvl + 3'd1;
            else if (!w_eol && w_dec) r_lvl <= r_lvl - 3'd1;
        end
    end

    // Per-lane read pointers; they stop at the last word and remember having read it.
    always_ff @(posedge CLK_IN or posedge RST_IN) begin
        if (RST_IN) begin
            for (int x = 0; x < 2; x++) begin
                r_end[x] <= '0;
                for (int l = 0; l < 4; l++) r_rptr[x][l] <= '0;
            end
        end else if (w_clr || LST_LRST_IN || LST_LNXT_IN) begin
            for (int x = 0; x < 2; x++) begin
                r_end[x] <= '0;
                for (int l = 0; l < 4; l++) r_rptr[x][l] <= '0;
            end
        end else begin
            for (int x = 0; x < 2; x++) begin
                for (int l = 0; l < 4; l++) begin
                    if (w_pop[x][l] && !r_end[x][l]) begin
                        if (({1'b0, r_rptr[x][l]} + {{AW{1'b0}}, 1'b1}) >= r_len[w_rslot[x]])
                            r_end[x][l] <= 1'b1;
                        else
                            r_rptr[x][l] <= r_rptr[x][l] + AW'(1);
                    end
                end
            end
        end
    end

    // One memory per lane; each window line owns a read port and a P_LAT-deep pipe.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [P_BPC-1:0] r_mem [P_SLOTS*P_WRDS];

        always_ff @(posedge CLK_IN) begin
            if (w_wr) r_mem[{r_wslot, r_waddr}] <= VID_DAT_IN[g*P_BPC +: P_BPC];
        end

        for (genvar x = 0; x < 2; x++) begin : g_line
            logic [P_BPC-1:0] r_pd [NST];
            logic [NST-1:0]   r_pv;
            logic [NST-1:0]   r_pz;
            logic [P_BPC-1:0] r_dat;
            logic             w_z;

`ifdef PRT_SCALER_LST_CLAMP_EN
            assign w_z = 1'b0;                 // re-read of last word replicates the edge
`else
            assign w_z = r_end[x][g];          // reads past the line end return zero
`endif

            always_ff @(posedge CLK_IN) begin
                r_pd[0] <= r_mem[{w_rslot[x], r_rptr[x][g]}];
                for (int i = 1; i < NST; i++) r_pd[i] <= r_pd[i-1];
            end

            always_ff @(posedge CLK_IN or posedge RST_IN) begin
                if (RST_IN) begin
                    r_pv  <= '0;
                    r_pz  <= '0;
                    r_dat <= '0;
                end else if (w_clr) begin
                    r_pv  <= '0;
                    r_pz  <= '0;
                    r_dat <= '0;
                end else begin
                    r_pv[0] <= w_pop[x][g];
                    r_pz[0] <= w_z;
                    for (int i = 1; i < NST; i++) begin
                        r_pv[i] <= r_pv[i-1];
                        r_pz[i] <= r_pz[i-1];
                    end
                    if (r_pv[NST-1]) r_dat <= r_pz[NST-1] ? '0 : r_pd[NST-1];
                end
            end

            assign w_lane[x][g] = r_dat;
        end
    end

    assign LST_DAT0_OUT = {w_lane[0][3], w_lane[0][2], w_lane[0][1], w_lane[0][0]};
    assign LST_DAT1_OUT = {w_lane[1][3], w_lane[1][2], w_lane[1][1], w_lane[1][0]};

endmodule
